// File: rtl/ga_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ga_controller_pkg
// Purpose : Shared types and constants for the genetic-algorithm route solver.
//           The state encoding doubles as the stage index, so stage_start /
//           stage_done bit positions equal the stage state values.
// Contents: states_t (3-bit FSM encoding), GA constants, stage_after().
// Revision: 1.0 - initial release
// ============================================================================
package ga_controller_pkg;

    typedef enum logic [2:0] {
        INITIALIZE  = 3'd0,
        RANK_ROUTES = 3'd1,
        SELECTION   = 3'd2,
        BREED       = 3'd3,
        MUTATE      = 3'd4,
        NEXT_GEN    = 3'd5,
        IDLE        = 3'd6,
        DONE        = 3'd7
    } states_t;

    localparam int NUM_STAGES = 6;

    // GA problem constants
    localparam int Number_of_Cities = 8;
    localparam int Population_Size  = 100;
    localparam int eliteSize        = 20;
    localparam int mutationRate     = 4;
    localparam int generations      = 500;

    // Linear successor of a stage; NEXT_GEN is resolved by the controller
    // because its successor depends on the generation/stall counters.
    function automatic states_t stage_after(input states_t s);
        case (s)
            INITIALIZE:  stage_after = RANK_ROUTES;
            RANK_ROUTES: stage_after = SELECTION;
            SELECTION:   stage_after = BREED;
            BREED:       stage_after = MUTATE;
            MUTATE:      stage_after = NEXT_GEN;
            default:     stage_after = RANK_ROUTES;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ga_stage_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : ga_stage_watchdog
// Purpose : Cycle watchdog for a single stage. Counts cycles while enabled;
//           expired is raised in the cycle that completes `limit` enabled
//           cycles since the last clear, so the owner can leave on that edge.
// Ports   : clk, rst_n (sync, active low), clear (zero the count),
//           enable (count this cycle), limit [CNT_W], expired (comb).
// Revision: 1.0 - initial release
// ============================================================================
module ga_stage_watchdog #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_cnt_inc;

    // One bit wider so a limit of all-ones never wraps the comparison.
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign expired   = enable && (w_cnt_inc >= {1'b0, limit});

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ga_controller.sv
`default_nettype none
// ============================================================================
// Module  : ga_controller
// Purpose : Top-level sequencer of the GA route solver. Walks the datapath
//           stages through start/done handshakes, counts generations, tracks
//           the best route distance, stops early on stagnation, and guards
//           each stage with a watchdog. Abort returns to IDLE from anywhere.
// Ports   : clk, rst_n (sync, active low), start, abort, stage_done[6],
//           rank_best[DIST_W] -> stage_start[6], state[3], gen_count[9],
//           best_dist[DIST_W], busy, done, timeout_err, early_stop.
// Revision: 1.0 - initial release
// ============================================================================
module ga_controller
    import ga_controller_pkg::*;
#(
    parameter int GENERATIONS = generations,
    parameter int STALL_LIMIT = 50,
    parameter int TIMEOUT     = 65535,
    parameter int DIST_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [5:0]        stage_done,
    input  logic [DIST_W-1:0] rank_best,
    output logic [5:0]        stage_start,
    output logic [2:0]        state,
    output logic [8:0]        gen_count,
    output logic [DIST_W-1:0] best_dist,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              early_stop
);

    localparam int             WD_W           = $clog2(TIMEOUT + 1);
    localparam logic [8:0]     C_GEN_TARGET   = 9'(GENERATIONS);
    localparam logic [15:0]    C_STALL_LIMIT  = 16'(STALL_LIMIT);
    localparam logic [WD_W-1:0] C_WD_LIMIT    = WD_W'(TIMEOUT);

    states_t     r_state;
    states_t     w_next;
    logic [15:0] r_stall;
    logic [8:0]  w_gen_inc;
    logic [7:0]  w_done_vec;
    logic        w_in_stage;
    logic        w_next_is_stage;
    logic        w_stage_done;
    logic        w_gen_last;
    logic        w_stalled;
    logic        w_wd_expired;
    logic        w_idle_start;

    assign w_in_stage      = (r_state != IDLE) && (r_state != DONE);
    assign w_next_is_stage = (w_next != IDLE) && (w_next != DONE);
    assign w_done_vec      = {2'b00, stage_done};

    // stage_start is only high in a stage's first cycle, so gating on it
    // drops a done that arrives together with its own start pulse.
    assign w_stage_done = w_in_stage && (stage_start == '0) && w_done_vec[r_state];
    assign w_idle_start = !w_in_stage && start;

    assign w_gen_inc  = gen_count + 9'd1;
    assign w_gen_last = (w_gen_inc == C_GEN_TARGET);
    assign w_stalled  = (STALL_LIMIT != 0) && (r_stall >= C_STALL_LIMIT);

    ga_stage_watchdog #(
        .CNT_W (WD_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_next != r_state),
        .enable  (w_in_stage),
        .limit   (C_WD_LIMIT),
        .expired (w_wd_expired)
    );

    // Next-state: abort > stage done > watchdog expiry > start.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) w_next = INITIALIZE;
                end
                NEXT_GEN: begin
                    if (w_stage_done)
                        w_next = (w_gen_last || w_stalled) ? DONE : RANK_ROUTES;
                    else if (w_wd_expired)
                        w_next = DONE;
                end
                default: begin
                    if (w_stage_done)
                        w_next = stage_after(r_state);
                    else if (w_wd_expired)
                        w_next = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            stage_start <= '0;
            gen_count   <= '0;
            best_dist   <= '1;
            r_stall     <= '0;
            timeout_err <= 1'b0;
            early_stop  <= 1'b0;
        end else begin
            r_state     <= w_next;
            stage_start <= '0;
            if ((w_next != r_state) && w_next_is_stage)
                stage_start <= 6'b000001 << w_next;

            if (!abort) begin
                if (w_idle_start) begin
                    gen_count   <= '0;
                    best_dist   <= '1;
                    r_stall     <= '0;
                    timeout_err <= 1'b0;
                    early_stop  <= 1'b0;
                end

                if (w_stage_done && (r_state == RANK_ROUTES)) begin
                    if (rank_best < best_dist) begin
                        best_dist <= rank_best;
                        r_stall   <= '0;
                    end else if (r_stall != '1) begin
                        r_stall   <= r_stall + 16'd1;
                    end
                end

                if (w_stage_done && (r_state == NEXT_GEN)) begin
                    gen_count <= w_gen_inc;
                    // Reaching the generation target is a normal finish even
                    // if the stall limit is met on the same generation.
                    if (!w_gen_last && w_stalled)
                        early_stop <= 1'b1;
                end

                if (!w_stage_done && w_wd_expired)
                    timeout_err <= 1'b1;
            end
        end
    end

    assign state = r_state;
    assign busy  = w_in_stage;
    assign done  = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/ga_controller.md
Name: ga_controller

Overview:
- Top-level sequencer for the genetic-algorithm route solver.
- Steps the GA datapath stages (initialize, rank, select, breed, mutate, next-gen) through start/done handshakes and counts generations.
- Tracks the best route distance, with early stop on stagnation, a per-stage watchdog and abort.
- Sits between the host start/abort interface and the stage sub-blocks.

Parameters:
- GENERATIONS, 500, number of generations to run before DONE.
- STALL_LIMIT, 50, consecutive non-improving generations that force early DONE; 0 disables early stop.
- TIMEOUT, 65535, maximum cycles any stage may take to return done.
- DIST_W, 16, width of the route-distance value.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level; honoured only in IDLE or DONE.
- abort  in  1  level; forces IDLE on the next edge from any state.
- stage_done  in  6  per-stage done pulse, index = STATES encoding 0..5 (INITIALIZE..NEXT_GEN).
- rank_best  in  DIST_W  best distance of the current population; valid with stage_done[RANK_ROUTES].
- stage_start  out  6  one-hot one-cycle start pulse to the stage sub-blocks.
- state  out  3  current STATES value.
- gen_count  out  9  completed generations.
- best_dist  out  DIST_W  best distance seen this run.
- busy  out  1  high when state is neither IDLE nor DONE.
- done  out  1  high while in DONE.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared on start.
- early_stop  out  1  sticky; set when the stall limit ends a run, cleared on start.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, stage_start=0, gen_count=0, best_dist=all-ones, busy=0, done=0, timeout_err=0, early_stop=0. Internal stall and watchdog counters are 0. Reset mid-run discards all progress.
- FSM sequence: IDLE -> INITIALIZE -> RANK_ROUTES -> SELECTION -> BREED -> MUTATE -> NEXT_GEN -> (RANK_ROUTES or DONE).
- Stage entry: stage_start[state] is registered and asserted exactly in the first cycle the state register holds that stage. It is never asserted in IDLE or DONE.
- Stage exit: the FSM leaves a stage on the edge where stage_done[state]=1.
  - Done arriving in the same cycle as that stage's start pulse is ignored.
  - stage_done bits not matching the current state are ignored.
  - Minimum stage latency is 2 cycles (start cycle + done cycle).
- IDLE or DONE with start=1: go to INITIALIZE; clear gen_count, best_dist (all-ones), stall counter, timeout_err, early_stop.
- RANK_ROUTES done:
  - rank_best < best_dist (unsigned): best_dist <= rank_best; stall counter <= 0.
  - Otherwise: stall counter +1, saturating.
- NEXT_GEN done: gen_count +1, then:
  - If the new gen_count == GENERATIONS -> DONE.
  - Else if STALL_LIMIT != 0 and the stall counter >= STALL_LIMIT -> DONE with early_stop=1.
  - Else -> RANK_ROUTES.
  - gen_count never exceeds GENERATIONS; no wrap.
- Watchdog:
  - Counter clears on every state change and increments each cycle in a stage state.
  - If it reaches TIMEOUT without done -> DONE with timeout_err=1.
  - Done and expiry in the same cycle: done wins.
- Abort: highest priority over done, timeout and start. Next state is IDLE; gen_count and best_dist are held for inspection; stage_start=0.
- DONE: done=1, outputs held until start or abort.
- Start during busy is ignored.

Decomposition:
- Package global: extend STATES to 8 values in 3 bits: INITIALIZE=0, RANK_ROUTES=1, SELECTION=2, BREED=3, MUTATE=4, NEXT_GEN=5, IDLE=6, DONE=7. Stage indices then equal the stage_start bit positions.
- Package global also holds the GA constants as localparams: Number_of_Cities=8, Population_Size=100, eliteSize=20, mutationRate=4, generations=500. GENERATIONS defaults from generations.
- One sub-module: ga_stage_watchdog (clear, enable, limit, expired), reusable by the stage blocks.

Test Plan:
- Full run, GENERATIONS=3, each stage done 2 cycles after start, rank_best 900/800/700:
  - gen_count reaches 3, DONE, best_dist=700, early_stop=0.
  - stage_start pulses count: INITIALIZE 1, RANK_ROUTES 3, others 3 each.
- Stall, STALL_LIMIT=2, rank_best constant 500:
  - gen 1 improves; gens 2-3 stall; DONE after gen_count=3 with early_stop=1, best_dist=500.
- Watchdog, TIMEOUT=10, BREED never done:
  - DONE exactly 10 cycles after BREED entry; timeout_err=1.
  - Then start=1 clears timeout_err and enters INITIALIZE.
- Handshake edges:
  - Done in the same cycle as the start pulse is ignored.
  - stage_done[BREED] while in SELECTION is ignored.
  - Done together with watchdog expiry advances normally.
- Abort in MUTATE at gen_count=2 -> IDLE next cycle, gen_count=2 held. rst_n=0 mid-run -> all outputs at reset values next cycle.
